// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
//   hz_state_e      : controller FSM state (2-bit encoding)
//   REG_IDX_W       : architectural register index width
//   MD_CNT_W        : multiply/divide wait counter width
//   MD_TIMEOUT_DFLT : default multiply/divide timeout in cycles
//   PERF_CNT_W      : width of the optional performance counters
package hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W       = 5;
  localparam int unsigned MD_CNT_W        = 8;
  localparam int unsigned MD_TIMEOUT_DFLT = 40;
  localparam int unsigned PERF_CNT_W      = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter32.sv
// Saturating 32-bit event counter used by the hazard controller.
//   clk     : rising-edge clock
//   rst     : synchronous active-low clear
//   i_inc   : count one event this cycle
//   o_count : current count, sticks at all-ones
module sat_counter32
  import hazard_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_inc,
  output logic [PERF_CNT_W-1:0] o_count
);

  logic [PERF_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + PERF_CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory wait, multiply/divide wait with
// timeout, load-use interlock and taken-branch flush.
// Optional macro HAZARD_PERF_CNT_EN adds stall/flush event counters.
//   clk, rst                       : clock, synchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/rs2  : ID source registers and their use
//   ex_load, ex_rd                 : EX load and its destination
//   ex_branch_taken                : EX redirect
//   ex_md_start, md_done           : EX M-extension op, M-unit result valid
//   mem_req, mem_ready             : MEM data access and its completion
//   stall_if/id/ex/mem             : hold PC / IF-ID / ID-EX / EX-MEM
//   flush_id/ex/mem/wb             : bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
//   md_abort                       : one-cycle M-unit timeout pulse
//   busy                           : FSM not in RUN
//   stall_cycles, flush_events     : (HAZARD_PERF_CNT_EN) event counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 ex_md_start,
  input  logic                 md_done,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 flush_mem,
  output logic                 flush_wb,
  output logic                 md_abort,
  output logic                 busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_events
`endif
);

  // Abort fires in the MD_TIMEOUT-th stalled cycle, counting the start cycle.
  localparam logic [MD_CNT_W-1:0] TMO_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

  hz_state_e           r_state;
  hz_state_e           w_state_nxt;
  logic [MD_CNT_W-1:0] r_cnt;
  logic [MD_CNT_W-1:0] w_cnt_nxt;
  logic [MD_CNT_W-1:0] w_cnt_inc;
  logic                w_mem_wait;
  logic                w_md_pend;
  logic                w_timeout;
  logic                w_md_stall;
  logic                w_load_use;

  // Shared hazard conditions
  assign w_mem_wait = mem_req && !mem_ready;
  assign w_md_pend  = ex_md_start && !md_done;
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + MD_CNT_W'(1);
  assign w_timeout  = (r_state == ST_MD_WAIT) && w_md_pend && (w_cnt_inc >= TMO_LAST);
  assign w_md_stall = w_md_pend && !w_timeout;
  assign w_load_use = ex_load && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; counter clears in RUN, counts in MD_WAIT, freezes in MEM_WAIT
  always_comb begin
    w_state_nxt = ST_RUN;
    w_cnt_nxt   = r_cnt;
    if (w_mem_wait) begin
      w_state_nxt = ST_MEM_WAIT;
    end else if (w_md_stall) begin
      w_state_nxt = ST_MD_WAIT;
    end
    case (r_state)
      ST_RUN:     w_cnt_nxt = '0;
      ST_MD_WAIT: if (!w_mem_wait) w_cnt_nxt = w_cnt_inc;
      default:    w_cnt_nxt = r_cnt;
    endcase
  end

  // Output decode in priority order
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    md_abort  = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
      flush_wb  = 1'b1;
    end else begin
      busy = (r_state != ST_RUN);
      if (w_mem_wait) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
      end else if (w_md_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_mem = 1'b1;
      end else if (w_timeout) begin
        md_abort = 1'b1;
        flush_ex = 1'b1;
      end else if (ex_branch_taken) begin
        // A branch held in EX by a wait lands here on the release cycle
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (w_load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic w_any_stall;
  logic w_any_flush;

  assign w_any_stall = stall_if || stall_id || stall_ex || stall_mem;
  assign w_any_flush = flush_id || flush_ex || flush_mem || flush_wb;

  sat_counter32 u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_any_stall),
    .o_count (stall_cycles)
  );

  sat_counter32 u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_any_flush),
    .o_count (flush_events)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_TIMEOUT = 8).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_load, ex_branch_taken;
  logic       ex_md_start, md_done, mem_req, mem_ready;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex, flush_mem, flush_wb;
  logic       md_abort, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // {stall_if,stall_id,stall_ex,stall_mem, flush_id,flush_ex,flush_mem,flush_wb, md_abort,busy}
  logic [9:0] obs;
  assign obs = {stall_if, stall_id, stall_ex, stall_mem,
                flush_id, flush_ex, flush_mem, flush_wb, md_abort, busy};

  localparam logic [9:0] O_IDLE    = 10'b0000_0000_00;
  localparam logic [9:0] O_RST     = 10'b0000_1111_00;
  localparam logic [9:0] O_LU      = 10'b1100_0100_00;
  localparam logic [9:0] O_BR      = 10'b0000_1100_00;
  localparam logic [9:0] O_BR_BUSY = 10'b0000_1100_01;
  localparam logic [9:0] O_MD_RUN  = 10'b1110_0010_00;
  localparam logic [9:0] O_MD_W    = 10'b1110_0010_01;
  localparam logic [9:0] O_MD_DONE = 10'b0000_0000_01;
  localparam logic [9:0] O_ABORT   = 10'b0000_0100_11;
  localparam logic [9:0] O_MEM_RUN = 10'b1111_0001_00;
  localparam logic [9:0] O_MEM_W   = 10'b1111_0001_01;

  hazard_ctrl #(.MD_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_load(ex_load), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .md_done(md_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .md_abort(md_abort), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs are set at a negedge; check 1 time unit later, then move to next negedge.
  task automatic cyc(input string tag, input logic [9:0] exp);
    #1;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    @(negedge clk);
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_load = 0; ex_branch_taken = 0;
    ex_md_start = 0; md_done = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    rst = 1'b0;
    clr_in();
    cyc("reset_0", O_RST);
    cyc("reset_1", O_RST);
    rst = 1'b1;
    cyc("idle_after_reset", O_IDLE);

    // Load-use on rs2, then single-cycle only
    ex_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    cyc("load_use_rs2", O_LU);
    clr_in();
    cyc("load_use_release", O_IDLE);
    ex_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    cyc("load_use_rs1", O_LU);
    id_use_rs1 = 0;
    cyc("load_unused_src", O_IDLE);
    ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    cyc("load_x0", O_IDLE);
    clr_in();

    // Branch, and branch winning over load-use
    ex_branch_taken = 1;
    cyc("branch", O_BR);
    ex_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    cyc("branch_over_lu", O_BR);
    clr_in();
    cyc("branch_release", O_IDLE);

    // MD op, md_done on cycle 4
    ex_md_start = 1;
    cyc("md_c0", O_MD_RUN);
    for (int i = 1; i <= 3; i++) cyc($sformatf("md_c%0d", i), O_MD_W);
    md_done = 1;
    cyc("md_done_c4", O_MD_DONE);
    clr_in();
    cyc("md_run_c5", O_IDLE);

    // Zero-latency MD result causes no stall
    ex_md_start = 1; md_done = 1;
    cyc("md_zero_lat", O_IDLE);
    clr_in();
    cyc("md_zero_lat_next", O_IDLE);

    // Timeout: abort in cycle 7
    ex_md_start = 1;
    cyc("tmo_c0", O_MD_RUN);
    for (int i = 1; i <= 6; i++) cyc($sformatf("tmo_c%0d", i), O_MD_W);
    cyc("tmo_abort_c7", O_ABORT);
    clr_in();
    cyc("tmo_run_c8", O_IDLE);

    // Memory wait with branch held, flush on release
    mem_req = 1; ex_branch_taken = 1;
    cyc("mem_c0", O_MEM_RUN);
    cyc("mem_c1", O_MEM_W);
    cyc("mem_c2", O_MEM_W);
    mem_ready = 1;
    cyc("mem_release_branch", O_BR_BUSY);
    clr_in();
    cyc("mem_run", O_IDLE);

    // Memory wait preempting MD wait; counter frozen, so abort lands on cycle 10
    ex_md_start = 1;
    cyc("pre_c0", O_MD_RUN);
    cyc("pre_c1", O_MD_W);
    mem_req = 1;
    cyc("pre_mem_c2", O_MEM_W);
    cyc("pre_mem_c3", O_MEM_W);
    mem_ready = 1;
    cyc("pre_resume_c4", O_MD_W);
    mem_req = 0; mem_ready = 0;
    for (int i = 5; i <= 9; i++) cyc($sformatf("pre_md_c%0d", i), O_MD_W);
    cyc("pre_abort_c10", O_ABORT);
    clr_in();
    cyc("pre_run_c11", O_IDLE);

    // Reset during MD wait
    ex_md_start = 1;
    cyc("rst_md_c0", O_MD_RUN);
    cyc("rst_md_c1", O_MD_W);
    rst = 0;
    cyc("rst_mid_wait", O_RST);
    rst = 1; clr_in();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk32("stall_cycles_after_rst", stall_cycles, 32'd0);
    chk32("flush_events_after_rst", flush_events, 32'd0);
`endif
    cyc("rst_run_after", O_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    ex_branch_taken = 1;
    cyc("perf_branch", O_BR);
    clr_in();
    #1;
    chk32("flush_events_one", flush_events, 32'd1);
    chk32("stall_cycles_zero", stall_cycles, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
